// File: rtl/bist_scheduler.sv
// Arbitrates the MemorySet bank array between the host SPI path and a march-test
// engine (fill P, read P / write ~P, read ~P descending) that logs mismatches.
module bist_scheduler #(
    parameter int NUM_BANKS = 20,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int ERR_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_W-1:0]    pattern,
    input  logic                 host_req,
    input  logic                 host_rw,
    input  logic [4:0]           host_bank,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [DATA_W-1:0]    host_wdata,
    output logic                 host_gnt,
    output logic [NUM_BANKS-1:0] mem_cs,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_rw,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_W-1:0]     err_count,
    output logic                 fail_valid,
    output logic [4:0]           fail_bank,
    output logic [ADDR_W-1:0]    fail_addr
);
    typedef enum logic [2:0] {IDLE, W_FILL, RW_INV, R_CHK, DRAIN, DONE} state_t;

    localparam logic [4:0]        LAST_BANK = 5'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t              state_reg;
    logic [4:0]          bank_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                sub_reg;
    logic [DATA_W-1:0]   pat_reg;
    logic                pipe_valid_reg;
    logic [DATA_W-1:0]   pipe_exp_reg;
    logic [4:0]          pipe_bank_reg;
    logic [ADDR_W-1:0]   pipe_addr_reg;

    logic                eng_req;
    logic                eng_go;
    logic                eng_rw;
    logic                eng_read;
    logic [DATA_W-1:0]   eng_wdata;
    logic [DATA_W-1:0]   eng_exp;
    logic                asc_last;
    logic                desc_last;
    logic                sel_en;
    logic [4:0]          sel_bank;

    always_comb begin
        eng_req   = (state_reg == W_FILL) || (state_reg == RW_INV) || (state_reg == R_CHK);
        eng_go    = eng_req && !host_req;
        eng_rw    = (state_reg == W_FILL) || ((state_reg == RW_INV) && sub_reg);
        eng_wdata = (state_reg == W_FILL) ? pat_reg : ~pat_reg;
        eng_exp   = (state_reg == RW_INV) ? pat_reg : ~pat_reg;
        eng_read  = eng_go && !eng_rw;
        asc_last  = (bank_reg == LAST_BANK) && (addr_reg == LAST_ADDR);
        desc_last = (bank_reg == 5'd0) && (addr_reg == '0);
    end

    // Host always wins the cycle; an out-of-range host bank simply matches no select line.
    assign host_gnt = host_req;

    always_comb begin
        sel_en    = host_req || eng_req;
        sel_bank  = host_req ? host_bank  : bank_reg;
        mem_addr  = host_req ? host_addr  : addr_reg;
        mem_wdata = host_req ? host_wdata : eng_wdata;
        mem_rw    = host_req ? host_rw    : eng_rw;
    end

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_cs
            assign mem_cs[gi] = sel_en && (sel_bank == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            bank_reg       <= '0;
            addr_reg       <= '0;
            sub_reg        <= 1'b0;
            pat_reg        <= '0;
            pipe_valid_reg <= 1'b0;
            pipe_exp_reg   <= '0;
            pipe_bank_reg  <= '0;
            pipe_addr_reg  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            fail_bank      <= '0;
            fail_addr      <= '0;
        end else begin
            // Read data arrives one clock after the engine read; compare it against the captured expectation.
            pipe_valid_reg <= eng_read;
            pipe_exp_reg   <= eng_exp;
            pipe_bank_reg  <= bank_reg;
            pipe_addr_reg  <= addr_reg;
            if (pipe_valid_reg && (mem_rdata != pipe_exp_reg)) begin
                if (err_count != '1) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_bank  <= pipe_bank_reg;
                    fail_addr  <= pipe_addr_reg;
                end
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        pat_reg    <= pattern;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_bank  <= '0;
                        fail_addr  <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        bank_reg   <= '0;
                        addr_reg   <= '0;
                        sub_reg    <= 1'b0;
                        state_reg  <= W_FILL;
                    end
                end
                W_FILL: begin
                    if (eng_go) begin
                        if (asc_last) begin
                            bank_reg  <= '0;
                            addr_reg  <= '0;
                            sub_reg   <= 1'b0;
                            state_reg <= RW_INV;
                        end else begin
                            addr_reg <= addr_reg + ADDR_W'(1);
                            if (addr_reg == LAST_ADDR) begin
                                bank_reg <= bank_reg + 5'd1;
                            end
                        end
                    end
                end
                RW_INV: begin
                    if (eng_go) begin
                        if (!sub_reg) begin
                            sub_reg <= 1'b1;
                        end else begin
                            sub_reg <= 1'b0;
                            if (asc_last) begin
                                bank_reg  <= LAST_BANK;
                                addr_reg  <= LAST_ADDR;
                                state_reg <= R_CHK;
                            end else begin
                                addr_reg <= addr_reg + ADDR_W'(1);
                                if (addr_reg == LAST_ADDR) begin
                                    bank_reg <= bank_reg + 5'd1;
                                end
                            end
                        end
                    end
                end
                R_CHK: begin
                    if (eng_go) begin
                        if (desc_last) begin
                            state_reg <= DRAIN;
                        end else begin
                            addr_reg <= addr_reg - ADDR_W'(1);
                            if (addr_reg == '0) begin
                                bank_reg <= bank_reg - 5'd1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bist_scheduler.sv
// Bench for bist_scheduler: full-size clean run, a stuck-bit instance, and a small
// instance for host interference, saturation, reset-abort and start-while-busy.
module tb_bist_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst_c;
    logic        reset_c;
    logic        start;
    int          sel;
    logic        start_a, start_b, start_c;
    logic [7:0]  pattern;
    logic        host_req, host_rw;
    logic [4:0]  host_bank;
    logic [8:0]  host_addr;
    logic [7:0]  host_wdata;
    logic        stuck_all;

    logic        gnt_a, rw_a, busy_a, done_a, fv_a;
    logic [19:0] cs_a;
    logic [8:0]  addr_a, fa_a;
    logic [7:0]  wd_a, rd_a;
    logic [15:0] err_a;
    logic [4:0]  fb_a;

    logic        gnt_b, rw_b, busy_b, done_b, fv_b;
    logic [7:0]  cs_b;
    logic [8:0]  addr_b, fa_b;
    logic [7:0]  wd_b, rd_b;
    logic [15:0] err_b;
    logic [4:0]  fb_b;

    logic        gnt_c, rw_c, busy_c, done_c, fv_c;
    logic [7:0]  cs_c;
    logic [4:0]  addr_c, fa_c;
    logic [7:0]  wd_c, rd_c;
    logic [3:0]  err_c;
    logic [4:0]  fb_c;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);
    assign reset_c = rst | rst_c;

    bist_scheduler #(.NUM_BANKS(20), .ADDR_W(9), .DATA_W(8), .ERR_W(16)) dut_a (
        .clk(clk), .reset(rst), .start(start_a), .pattern(pattern),
        .host_req(host_req), .host_rw(host_rw), .host_bank(host_bank),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(gnt_a),
        .mem_cs(cs_a), .mem_addr(addr_a), .mem_wdata(wd_a), .mem_rw(rw_a),
        .mem_rdata(rd_a), .busy(busy_a), .done(done_a), .err_count(err_a),
        .fail_valid(fv_a), .fail_bank(fb_a), .fail_addr(fa_a));

    bist_scheduler #(.NUM_BANKS(8), .ADDR_W(9), .DATA_W(8), .ERR_W(16)) dut_b (
        .clk(clk), .reset(rst), .start(start_b), .pattern(pattern),
        .host_req(host_req), .host_rw(host_rw), .host_bank(host_bank),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(gnt_b),
        .mem_cs(cs_b), .mem_addr(addr_b), .mem_wdata(wd_b), .mem_rw(rw_b),
        .mem_rdata(rd_b), .busy(busy_b), .done(done_b), .err_count(err_b),
        .fail_valid(fv_b), .fail_bank(fb_b), .fail_addr(fa_b));

    bist_scheduler #(.NUM_BANKS(8), .ADDR_W(5), .DATA_W(8), .ERR_W(4)) dut_c (
        .clk(clk), .reset(reset_c), .start(start_c), .pattern(pattern),
        .host_req(host_req), .host_rw(host_rw), .host_bank(host_bank),
        .host_addr(host_addr[4:0]), .host_wdata(host_wdata), .host_gnt(gnt_c),
        .mem_cs(cs_c), .mem_addr(addr_c), .mem_wdata(wd_c), .mem_rw(rw_c),
        .mem_rdata(rd_c), .busy(busy_c), .done(done_c), .err_count(err_c),
        .fail_valid(fv_c), .fail_bank(fb_c), .fail_addr(fa_c));

    // MemorySet models: registered read, one byte per bank/address.
    logic [7:0] mem_a [20][512];
    logic [7:0] mem_b [8][512];
    logic [7:0] mem_c [8][32];

    always @(posedge clk) begin
        for (int b = 0; b < 20; b++) begin
            if (cs_a[b]) begin
                if (rw_a) mem_a[b][addr_a] <= wd_a;
                else      rd_a <= mem_a[b][addr_a];
            end
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (cs_b[b]) begin
                if (rw_b) mem_b[b][addr_b] <= wd_b;
                else      rd_b <= mem_b[b][addr_b] & (((b == 3) && (addr_b == 9'h1A5)) ? 8'hFE : 8'hFF);
            end
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (cs_c[b]) begin
                if (rw_c) mem_c[b][addr_c] <= wd_c;
                else      rd_c <= stuck_all ? 8'h00 : mem_c[b][addr_c];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        busy_s, done_s, fv_s, gnt_s, rw_s;
    logic [15:0] err_s;
    logic [4:0]  fb_s;
    logic [8:0]  fa_s, addr_s;
    logic [19:0] cs_s;
    logic [7:0]  wd_s;

    always_comb begin
        busy_s = busy_a; done_s = done_a; fv_s = fv_a; gnt_s = gnt_a; rw_s = rw_a;
        err_s = err_a; fb_s = fb_a; fa_s = fa_a; addr_s = addr_a; cs_s = cs_a; wd_s = wd_a;
        if (sel == 1) begin
            busy_s = busy_b; done_s = done_b; fv_s = fv_b; gnt_s = gnt_b; rw_s = rw_b;
            err_s = err_b; fb_s = fb_b; fa_s = fa_b; addr_s = addr_b; cs_s = {12'd0, cs_b}; wd_s = wd_b;
        end else if (sel == 2) begin
            busy_s = busy_c; done_s = done_c; fv_s = fv_c; gnt_s = gnt_c; rw_s = rw_c;
            err_s = {12'd0, err_c}; fb_s = fb_c; fa_s = {4'd0, fa_c}; addr_s = {4'd0, addr_c};
            cs_s = {12'd0, cs_c}; wd_s = wd_c;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_idle();
        host_req = 1'b0; host_rw = 1'b0; host_bank = 5'd0; host_addr = 9'd0; host_wdata = 8'd0;
    endtask

    typedef struct packed {
        logic        req;
        logic        rw;
        logic [4:0]  bank;
        logic [8:0]  addr;
        logic [7:0]  wd;
        logic        gnt;
        logic [19:0] cs;
    } vec_t;

    typedef struct {
        string       name;
        int          lo;
        int          hi;
        logic [15:0] err;
        logic        fv;
        logic [4:0]  fb;
        logic [8:0]  fa;
    } run_exp_t;

    vec_t     vecs [9];
    vec_t     arb_q [$];
    run_exp_t run_q [$];
    int       t0;

    task automatic start_run(input int which, input logic [7:0] p, input string name,
                             input int lo, input int hi, input logic [15:0] err,
                             input logic fv, input logic [4:0] fb, input logic [8:0] fa);
        run_exp_t e;
        e.name = name; e.lo = lo; e.hi = hi; e.err = err; e.fv = fv; e.fb = fb; e.fa = fa;
        run_q.push_back(e);
        sel = which; pattern = p; start = 1'b1;
        tick(1);
        start = 1'b0;
        t0 = cyc;
        chk({name, "_busy"}, {busy_s, done_s}, 2'b10);
    endtask

    task automatic finish_run(output int len);
        run_exp_t e;
        int lim;
        e = run_q.pop_front();
        lim = e.hi + 50;
        len = -1;
        for (int i = 0; i < lim; i++) begin
            tick(1);
            if (done_s) begin
                len = cyc - t0;
                break;
            end
        end
        if (len < 0) chk({e.name, "_timeout_done"}, done_s, 1'b1);
        chk_range({e.name, "_len"}, len, e.lo, e.hi);
        chk({e.name, "_busy_end"}, busy_s, 1'b0);
        chk({e.name, "_err"}, err_s, e.err);
        chk({e.name, "_fail"}, {fv_s, fb_s, fa_s}, {e.fv, e.fb, e.fa});
        $display("run %s: len=%0d err=%0d fail_valid=%0d bank=%0d addr=0x%0h",
                 e.name, len, err_s, fv_s, fb_s, fa_s);
    endtask

    int len, len_idle, bad_cells, gnt_cnt, cs_cnt;
    vec_t v;

    initial begin
        rst = 1'b1; rst_c = 1'b0; start = 1'b0; sel = 0; pattern = 8'h00; stuck_all = 1'b0;
        host_idle();
        tick(3);
        rst = 1'b0;
        tick(1);

        chk("rst_status_a", {busy_a, done_a, fv_a, err_a, fb_a, fa_a, cs_a}, 64'd0);
        chk("rst_status_c", {busy_c, done_c, fv_c, err_c, fb_c, fa_c, cs_c}, 64'd0);

        // Arbitration vectors on the idle full-size instance.
        vecs[0] = '{1'b0, 1'b0, 5'd0,  9'h000, 8'h00, 1'b0, 20'h00000};
        vecs[1] = '{1'b1, 1'b1, 5'd0,  9'h000, 8'h12, 1'b1, 20'h00001};
        vecs[2] = '{1'b1, 1'b0, 5'd19, 9'h1FF, 8'h00, 1'b1, 20'h80000};
        vecs[3] = '{1'b1, 1'b1, 5'd7,  9'h010, 8'h3C, 1'b1, 20'h00080};
        vecs[4] = '{1'b1, 1'b0, 5'd20, 9'h0AB, 8'h00, 1'b1, 20'h00000};
        vecs[5] = '{1'b1, 1'b1, 5'd25, 9'h155, 8'hFF, 1'b1, 20'h00000};
        vecs[6] = '{1'b1, 1'b0, 5'd31, 9'h001, 8'h00, 1'b1, 20'h00000};
        vecs[7] = '{1'b1, 1'b1, 5'd12, 9'h0F0, 8'hA5, 1'b1, 20'h01000};
        vecs[8] = '{1'b0, 1'b1, 5'd12, 9'h0F0, 8'hA5, 1'b0, 20'h00000};
        sel = 0;
        for (int i = 0; i < 9; i++) begin
            host_req = vecs[i].req; host_rw = vecs[i].rw; host_bank = vecs[i].bank;
            host_addr = vecs[i].addr; host_wdata = vecs[i].wd;
            arb_q.push_back(vecs[i]);
            @(negedge clk);
            v = arb_q.pop_front();
            chk($sformatf("arb%0d_gnt_cs", i), {gnt_s, cs_s}, {v.gnt, v.cs});
            if (v.req) chk($sformatf("arb%0d_fields", i), {addr_s, wd_s, rw_s}, {v.addr, v.wd, v.rw});
            $display("vec %0d: req=%0d bank=%0d gnt=%0d cs=0x%05h", i, v.req, v.bank, gnt_s, cs_s);
            tick(1);
        end
        host_idle();
        tick(1);

        // Full-size clean run; a start pulse mid-run must be ignored.
        start_run(0, 8'h55, "a_clean", 40961, 40965, 16'd0, 1'b0, 5'd0, 9'd0);
        tick(1000);
        pattern = 8'h33; start = 1'b1;
        tick(1);
        start = 1'b0;
        finish_run(len);
        bad_cells = 0;
        for (int b = 0; b < 20; b++)
            for (int a = 0; a < 512; a++)
                if (mem_a[b][a] !== 8'hAA) bad_cells++;
        chk("a_mem_all_aa", bad_cells, 0);
        tick(10);
        chk("a_no_restart", {busy_a, done_a}, 2'b01);

        // Single stuck bit at bank 3 / 0x1A5 bit 0.
        start_run(1, 8'h55, "b_stuck", 16385, 16389, 16'd1, 1'b1, 5'd3, 9'h1A5);
        finish_run(len);

        // Small instance reference run.
        start_run(2, 8'hA5, "c_idle", 1025, 1029, 16'd0, 1'b0, 5'd0, 9'd0);
        finish_run(len_idle);

        // Host holds the array for 100 clocks mid-fill.
        start_run(2, 8'hA5, "c_hold", len_idle + 100, len_idle + 100, 16'd0, 1'b0, 5'd0, 9'd0);
        tick(10);
        host_req = 1'b1; host_rw = 1'b0; host_bank = 5'd5; host_addr = 9'd3;
        gnt_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gnt_c && cs_c == 8'h20) gnt_cnt++;
            tick(1);
        end
        host_idle();
        @(negedge clk);
        chk("c_hold_gnt_cycles", gnt_cnt, 100);
        chk("c_hold_resume", {cs_c, addr_c, rw_c, wd_c}, {8'h01, 5'd10, 1'b1, 8'hA5});
        finish_run(len);

        // Host write corrupts bank 7 / 0x10 before R_CHK reaches it; out-of-range read.
        start_run(2, 8'h5A, "c_hostwr", len_idle + 2, len_idle + 2, 16'd1, 1'b1, 5'd7, 9'h010);
        tick(770);
        host_req = 1'b1; host_rw = 1'b1; host_bank = 5'd7; host_addr = 9'h010; host_wdata = 8'h00;
        tick(1);
        host_rw = 1'b0; host_bank = 5'd25; host_addr = 9'h003;
        @(negedge clk);
        chk("c_bank25_drop", {gnt_c, cs_c}, {1'b1, 8'h00});
        tick(1);
        host_idle();
        finish_run(len);

        // Every location reads 0x00: the 4-bit counter saturates.
        stuck_all = 1'b1;
        start_run(2, 8'h55, "c_sat", len_idle, len_idle, 16'd15, 1'b1, 5'd0, 9'd0);
        finish_run(len);
        stuck_all = 1'b0;

        // Reset in the middle of RW_INV aborts the run.
        sel = 2; pattern = 8'h0F; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(256 + 20);
        rst_c = 1'b1;
        tick(1);
        rst_c = 1'b0;
        @(negedge clk);
        chk("c_rst_abort", {busy_c, done_c, cs_c}, {1'b0, 1'b0, 8'h00});
        cs_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (cs_c != 8'h00 || busy_c) cs_cnt++;
        end
        chk("c_rst_quiet", cs_cnt, 0);
        chk("c_rst_status", {done_c, fv_c, err_c}, 6'd0);
        $display("run c_reset: busy=%0d done=%0d err=%0d", busy_c, done_c, err_c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bist_scheduler.md
Name: bist_scheduler

Overview:
- Shares the MemorySet bank array between the SPI command FSM (host) and an internal march-test engine.
- The engine writes, verifies and inverts a byte pattern across all banks, then counts mismatches and captures the first failing location.
- Sits between the SPI FSM/address mapper and MemorySet. It drives the per-bank chip selects, byte address, write data and rw.
- The host always has priority; the engine only uses cycles the host leaves idle.

Parameters:
- NUM_BANKS, 20, number of RAM banks (width of mem_cs).
- ADDR_W, 9, byte address width per bank.
- DATA_W, 8, data byte width.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begins a test run when idle.
- pattern  in  DATA_W  test byte P; sampled on an accepted start.
- host_req  in  1  host requests a memory cycle this clock.
- host_rw  in  1  1 = write, 0 = read.
- host_bank  in  5  host bank index.
- host_addr  in  ADDR_W  host byte address.
- host_wdata  in  DATA_W  host write byte.
- host_gnt  out  1  host cycle issued this clock (combinational).
- mem_cs  out  NUM_BANKS  one-hot bank select to MemorySet.
- mem_addr  out  ADDR_W  byte address to MemorySet.
- mem_wdata  out  DATA_W  write byte to MemorySet.
- mem_rw  out  1  1 = write, 0 = read.
- mem_rdata  in  DATA_W  MemorySet read data; valid one clk after a read cycle.
- busy  out  1  test run in progress.
- done  out  1  high from end of a run until the next accepted start or reset.
- err_count  out  ERR_W  mismatch count, saturating.
- fail_valid  out  1  at least one mismatch captured.
- fail_bank  out  5  bank of the first mismatch.
- fail_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset: state IDLE. busy, done, fail_valid = 0. err_count, fail_bank, fail_addr = 0. Pipeline valid bit cleared. Reset mid-run aborts the run without completion; no further engine cycles are issued.
- Arbitration (combinational):
  - If host_req = 1, host_gnt = 1 and the host drives mem_*.
  - If host_bank >= NUM_BANKS, mem_cs = 0 (access dropped), host_gnt still 1.
  - If host_req = 0 and the engine needs a cycle, the engine drives mem_*.
  - Otherwise mem_cs = 0.
  - A host-stolen cycle stalls the engine: its address and sub-step do not advance.
- start is ignored while busy. Accepted in IDLE or DONE: latches P, clears err_count/fail_*/done, sets busy, enters W_FILL at bank 0, address 0.
- Address walk: address is the inner loop and bank the outer loop. Ascending runs bank 0..NUM_BANKS-1, addr 0..2^ADDR_W-1. Descending is the exact reverse.
- W_FILL (ascending): write P, one cycle per location. After the last location -> RW_INV.
- RW_INV (ascending): per location, sub-step R reads, then sub-step W writes ~P to the same location. Two engine cycles per location. After the last location -> R_CHK.
- R_CHK (descending): read each location, one cycle each. After the last issue -> DRAIN.
- DRAIN: wait one clk for the final compare. Then done = 1, busy = 0 -> DONE.
- DONE -> IDLE semantics: outputs hold until the next start or reset.
- Compare pipeline:
  - Every engine read registers valid, expected byte (P in RW_INV, ~P in R_CHK), bank and addr.
  - On the next clk, mem_rdata is compared against the expected byte, regardless of host activity that cycle.
  - On mismatch: err_count increments, saturating at 2^ERR_W-1.
  - If fail_valid = 0, it also captures bank/addr and sets fail_valid. Later mismatches never overwrite the capture.
- Host reads during a run return current memory contents; host writes may corrupt the test and are counted as normal mismatches.
- Host-idle run length: 4 × NUM_BANKS × 2^ADDR_W + 1 engine clk (40 961 at default), plus one clk per state transition.

Test Plan:
- Reset, then start with P = 0x55, host idle, fault-free model -> busy for ≤ 40 965 clk. Then done = 1, err_count = 0, fail_valid = 0, and all memory reads back 0xAA.
- Model with bank 3 addr 0x1A5 bit0 stuck-at-0, P = 0x55 -> err_count = 1, fail_bank = 3, fail_addr = 0x1A5. The R_CHK read of 0xAA passes.
- Host_req held high for 100 clk mid-W_FILL, then released -> host_gnt = 1 on all 100 clk. Engine address frozen during the hold. Run ends 100 clk later than the idle case with err_count = 0.
- Host write 0x00 to bank 7 addr 0x010 during R_CHK before that location is read -> err_count = 1, fail_bank = 7, fail_addr = 0x010. A host read of bank 25 gives mem_cs = 0 and host_gnt = 1.
- All locations stuck at 0x00 with ERR_W = 4 -> err_count saturates at 15, fail_bank = 0, fail_addr = 0.
- Reset asserted mid-RW_INV -> next clk busy = 0, done = 0, mem_cs = 0. A start pulse while busy is ignored: the run completes once with no restart.
